or1k_trace_nop_decoder: RTL

- Synthesizable per-core consumer of the mor1kx execution trace (`mor1kx_trace_exec` fields) in the or1k_mpsoc4d tile.
- Keeps a shadow copy of r3 and decodes simulation l.nop codes (exit, report, putc, silent exit).
- Emits decoded events through a small buffered valid/ready stream for a debug or host drain.
- Drives the per-core termination flag and the system-wide all-done flag that the simulation monitors consume.

---
 rtl/or1k_trace_pkg.sv | 28 ++
 rtl/or1k_trace_evt_fifo.sv | 47 ++++
 rtl/or1k_trace_nop_decoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/or1k_trace_pkg.sv
// Shared types and constants for the mor1kx trace nop decoder.
// Event encoding, simulation l.nop codes and decoder states.
package or1k_trace_pkg;

  typedef enum logic [1:0] {
    EVT_EXIT   = 2'd0,
    EVT_REPORT = 2'd1,
    EVT_PUTC   = 2'd2
  } evt_type_e;

  localparam logic [7:0]  NOP_OPCODE      = 8'h15;
  localparam logic [15:0] NOP_EXIT        = 16'd1;
  localparam logic [15:0] NOP_REPORT      = 16'd2;
  localparam logic [15:0] NOP_PUTC        = 16'd4;
  localparam logic [15:0] NOP_EXIT_SILENT = 16'd12;

  typedef struct packed {
    evt_type_e   kind;
    logic [31:0] data;
    logic [15:0] id;
  } evt_t;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_TERMINATED = 1'b1
  } dec_state_e;

endpackage

// File: rtl/or1k_trace_evt_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is taken only
// when a pop frees a slot in the same cycle.
module or1k_trace_evt_fifo
  import or1k_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  evt_t         mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed between the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/or1k_trace_nop_decoder.sv
// Per-core mor1kx trace consumer: shadows r3, decodes simulation l.nop codes
// and reports exit/report/putc events plus termination flags.
//
// state         | meaning
// ST_RUN        | decoding nops, core still running
// ST_TERMINATED | exit seen; nops ignored, r3 and event drain continue
module or1k_trace_nop_decoder
  import or1k_trace_pkg::*;
#(
  parameter int ID             = 0,
  parameter int TERM_CROSS_NUM = 16,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_valid,
  input  logic [31:0]               trace_pc,
  input  logic [31:0]               trace_insn,
  input  logic                      trace_wben,
  input  logic [4:0]                trace_wbreg,
  input  logic [31:0]               trace_wbdata,
  input  logic [TERM_CROSS_NUM-1:0] term_all_i,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [1:0]                evt_type,
  output logic [31:0]               evt_data,
  output logic [15:0]               evt_id,
  output logic                      termination_o,
  output logic [31:0]               exit_code_o,
  output logic                      all_done_o,
  output logic                      overflow_o
);

  localparam logic [15:0] ID_W = 16'(ID);

  dec_state_e  state_q, state_d;
  logic [31:0] r3_q;
  logic        is_nop;
  logic [15:0] nop_k;
  logic        push;
  logic        term_set;
  evt_t        push_evt;
  evt_t        head;
  logic        full;
  logic        empty;
  logic        pop;

  // PC is carried by the trace bundle but nothing here depends on it.
  logic        unused_pc;
  assign unused_pc = ^trace_pc;

  assign is_nop = trace_valid && (trace_insn[31:24] == NOP_OPCODE);
  assign nop_k  = trace_insn[15:0];
  assign pop    = evt_ready && !empty;

  always_comb begin
    state_d       = state_q;
    push          = 1'b0;
    term_set      = 1'b0;
    push_evt      = '0;
    push_evt.id   = ID_W;
    push_evt.data = r3_q;
    if (state_q == ST_RUN && is_nop) begin
      case (nop_k)
        NOP_EXIT: begin
          push          = 1'b1;
          push_evt.kind = EVT_EXIT;
          term_set      = 1'b1;
          state_d       = ST_TERMINATED;
        end
        NOP_EXIT_SILENT: begin
          term_set = 1'b1;
          state_d  = ST_TERMINATED;
        end
        NOP_REPORT: begin
          push          = 1'b1;
          push_evt.kind = EVT_REPORT;
        end
        NOP_PUTC: begin
          push          = 1'b1;
          push_evt.kind = EVT_PUTC;
          push_evt.data = {24'h0, r3_q[7:0]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      r3_q          <= '0;
      termination_o <= 1'b0;
      exit_code_o   <= '0;
      all_done_o    <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      all_done_o <= &term_all_i;
      // The nop itself reads r3_q before this write lands: no bypass needed.
      if (trace_valid && trace_wben && trace_wbreg == 5'd3) r3_q <= trace_wbdata;
      if (term_set) begin
        termination_o <= 1'b1;
        exit_code_o   <= r3_q;
      end
      if (push && full && !pop) overflow_o <= 1'b1;
    end
  end

  or1k_trace_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign evt_valid = !empty;
  assign evt_type  = empty ? 2'b00 : head.kind;
  assign evt_data  = empty ? 32'h0 : head.data;
  assign evt_id    = empty ? 16'h0 : head.id;

endmodule
